// File: rtl/pp_in_stage4_pkg.sv
// rtl/pp_in_stage4_pkg.sv - shared constants and helpers for the four-port ingress stage
package pp_in_stage4_pkg;

  localparam int PP_NPORT  = 4;
  localparam int PP_PORT_W = 2;
  localparam int PP_CNT_W  = 16;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [PP_CNT_W-1:0] pp_sat_inc(input logic [PP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pp_desc_fifo.sv
// rtl/pp_desc_fifo.sv - single-clock descriptor FIFO with registered count and head-of-queue read
module pp_desc_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/pp_in_stage4.sv
// rtl/pp_in_stage4.sv - four-port ingress staging ahead of the round-robin arbiter
// Optional per-port pop counters on cnt_out when PP_IN_STAGE_CNT_EN is defined.
module pp_in_stage4
  import pp_in_stage4_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PP_NPORT-1:0]    in_vld,
  input  logic [PP_NPORT*DW-1:0] in_data,
  output logic [PP_NPORT-1:0]    in_rdy,
  output logic [PP_NPORT-1:0]    arb_req,
  output logic                   arb_en,
  input  logic [PP_PORT_W-1:0]   arb_sel,
  output logic                   out_vld,
  output logic [DW-1:0]          out_data,
  output logic [PP_PORT_W-1:0]   out_port,
  input  logic                   out_rdy
`ifdef PP_IN_STAGE_CNT_EN
  ,
  output logic [PP_NPORT*PP_CNT_W-1:0] cnt_out
`endif
);

  logic [PP_NPORT-1:0] full;
  logic [PP_NPORT-1:0] empty;
  logic [PP_NPORT-1:0] push;
  logic [PP_NPORT-1:0] pop_vec;
  logic [DW-1:0]       head [PP_NPORT];
  logic                space;
  logic                pop;

  for (genvar p = 0; p < PP_NPORT; p++) begin : g_port
    assign push[p] = in_vld[p] & in_rdy[p];

    pp_desc_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[p]),
      .pop   (pop_vec[p]),
      .din   (in_data[p*DW +: DW]),
      .dout  (head[p]),
      .full  (full[p]),
      .empty (empty[p])
    );
  end

  assign in_rdy  = ~full;
  assign arb_req = ~empty;
  assign space   = ~out_vld | out_rdy;
  assign pop     = arb_req[arb_sel] & space;
  // Hold the arbiter pointer only while a non-empty port waits on a stalled output.
  assign arb_en  = pop | ~arb_req[arb_sel];

  always_comb begin
    pop_vec          = '0;
    pop_vec[arb_sel] = pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_port <= '0;
    end else if (pop) begin
      out_vld  <= 1'b1;
      out_data <= head[arb_sel];
      out_port <= arb_sel;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

`ifdef PP_IN_STAGE_CNT_EN
  logic [PP_CNT_W-1:0] cnt [PP_NPORT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PP_NPORT; p++) cnt[p] <= '0;
    end else begin
      for (int p = 0; p < PP_NPORT; p++) begin
        if (pop_vec[p]) cnt[p] <= pp_sat_inc(cnt[p]);
      end
    end
  end

  for (genvar p = 0; p < PP_NPORT; p++) begin : g_cnt
    assign cnt_out[p*PP_CNT_W +: PP_CNT_W] = cnt[p];
  end
`endif

endmodule

// File: tb/tb_pp_in_stage4.sv
// tb/tb_pp_in_stage4.sv - directed self-checking bench for pp_in_stage4
module tb_pp_in_stage4;

  localparam int DW = 64;

  logic          clk;
  logic          reset;
  logic [3:0]    in_vld;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_rdy;
  logic [3:0]    arb_req;
  logic          arb_en;
  logic [1:0]    arb_sel;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic [1:0]    out_port;
  logic          out_rdy;
`ifdef PP_IN_STAGE_CNT_EN
  logic [63:0]   cnt_out;
`endif

  logic          rr_mode;
  logic [1:0]    fixed_sel;
  logic [1:0]    rr_ptr;

  int checks;
  int errors;

  pp_in_stage4 #(.DW(DW), .DEPTH(4)) dut (
`ifdef PP_IN_STAGE_CNT_EN
    .cnt_out  (cnt_out),
`endif
    .clk      (clk),
    .reset    (reset),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .arb_req  (arb_req),
    .arb_en   (arb_en),
    .arb_sel  (arb_sel),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_port (out_port),
    .out_rdy  (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural arbiter: registered pointer, steps by one whenever enabled.
  always @(posedge clk) begin
    if (reset)       rr_ptr <= 2'd0;
    else if (arb_en) rr_ptr <= rr_ptr + 2'd1;
  end

  assign arb_sel = rr_mode ? rr_ptr : fixed_sel;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_vld  = 4'h0;
    in_data = '0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rr_mode   = 1'b0;
    fixed_sel = 2'd0;
    do_reset();
    checks++; if (in_rdy !== 4'hF)   begin errors++; $display("FAIL reset_in_rdy got %h exp f", in_rdy); end
    checks++; if (out_vld !== 1'b0)  begin errors++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
    checks++; if (arb_req !== 4'h0)  begin errors++; $display("FAIL reset_arb_req got %h exp 0", arb_req); end
    checks++; if (arb_en !== 1'b1)   begin errors++; $display("FAIL reset_arb_en got %b exp 1", arb_en); end
    checks++; if (out_data !== '0 || out_port !== 2'd0)
      begin errors++; $display("FAIL reset_out_regs got %h/%0d exp 0/0", out_data, out_port); end
`ifdef PP_IN_STAGE_CNT_EN
    checks++; if (cnt_out !== 64'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", cnt_out); end
`endif
  endtask

  task automatic test_single_port();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 64'hA; exp_d[1] = 64'hB; exp_d[2] = 64'hC;
    rr_mode   = 1'b0;
    fixed_sel = 2'd2;
    do_reset();
    out_rdy = 1'b1;
    in_vld  = 4'b0100;
    in_data[2*DW +: DW] = exp_d[0];
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b exp 0", out_vld); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) in_data[2*DW +: DW] = exp_d[i+1];
      else       in_vld = 4'h0;
      tick();
      checks++;
      if (out_vld !== 1'b1 || out_data !== exp_d[i] || out_port !== 2'd2) begin
        errors++;
        $display("FAIL single_out%0d got vld=%b data=%h port=%0d exp 1/%h/2", i, out_vld, out_data, out_port, exp_d[i]);
      end
    end
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_vld); end
  endtask

  task automatic test_fill_and_stall();
    rr_mode   = 1'b0;
    fixed_sel = 2'd1;
    do_reset();
    in_vld = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      in_data[DW-1:0] = 64'h10 + 64'(i);
      tick();
    end
    checks++; if (in_rdy !== 4'b1110) begin errors++; $display("FAIL full_in_rdy got %b exp 1110", in_rdy); end
    in_data[DW-1:0] = 64'h14;
    tick();
    in_vld = 4'h0;
    checks++; if (in_rdy !== 4'b1110) begin errors++; $display("FAIL full_5th_push got %b exp 1110", in_rdy); end
    fixed_sel = 2'd0;
    tick();
    checks++; if (out_vld !== 1'b1 || out_data !== 64'h10) begin errors++; $display("FAIL stall_first got %b/%h exp 1/10", out_vld, out_data); end
    checks++; if (arb_en !== 1'b0) begin errors++; $display("FAIL stall_arb_en got %b exp 0", arb_en); end
    tick();
    checks++; if (out_data !== 64'h10 || in_rdy !== 4'hF) begin errors++; $display("FAIL stall_hold got %h/%h exp 10/f", out_data, in_rdy); end
    out_rdy = 1'b1;
    #1;
    checks++; if (arb_en !== 1'b1) begin errors++; $display("FAIL resume_arb_en got %b exp 1", arb_en); end
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (out_vld !== 1'b1 || out_data !== 64'h10 + 64'(i)) begin
        errors++; $display("FAIL resume_out%0d got %b/%h exp 1/%h", i, out_vld, out_data, 64'h10 + 64'(i));
      end
    end
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL full_reject got vld=%b data=%h exp 0", out_vld, out_data); end
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_port;
    logic [DW-1:0] exp_data;
    rr_mode = 1'b1;
    do_reset();
    out_rdy = 1'b1;
    in_vld  = 4'hF;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 4; p++) in_data[p*DW +: DW] = 64'h100 * 64'(p) + 64'(k);
      tick();
    end
    in_vld = 4'h0;
    for (int i = 0; i < 8; i++) begin
      exp_port = 2'((i + 1) % 4);
      exp_data = 64'h100 * 64'(exp_port) + 64'(i / 4);
      checks++;
      if (out_vld !== 1'b1 || out_port !== exp_port || out_data !== exp_data) begin
        errors++;
        $display("FAIL rr_out%0d got vld=%b port=%0d data=%h exp 1/%0d/%h", i, out_vld, out_port, out_data, exp_port, exp_data);
      end
      tick();
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", out_vld); end
`ifdef PP_IN_STAGE_CNT_EN
    checks++; if (cnt_out !== 64'h0002_0002_0002_0002) begin errors++; $display("FAIL rr_cnt got %h exp 0002000200020002", cnt_out); end
`endif
  endtask

  task automatic test_reset_mid_stream();
    rr_mode   = 1'b0;
    fixed_sel = 2'd3;
    do_reset();
    in_vld = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      in_data[3*DW +: DW] = 64'h30 + 64'(i);
      tick();
    end
    in_vld = 4'h0;
    checks++; if (out_vld !== 1'b1 || arb_req !== 4'b1000) begin errors++; $display("FAIL mid_pre got %b/%b exp 1/1000", out_vld, arb_req); end
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    out_rdy = 1'b1;
    checks++; if (out_vld !== 1'b0 || arb_req !== 4'h0) begin errors++; $display("FAIL mid_reset got %b/%b exp 0/0000", out_vld, arb_req); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got vld=%b data=%h exp 0", i, out_vld, out_data); end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    rr_mode   = 1'b0;
    fixed_sel = 2'd0;
    in_vld    = 4'h0;
    in_data   = '0;
    out_rdy   = 1'b0;
    test_reset();
    test_single_port();
    test_fill_and_stall();
    test_round_robin();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pp_in_stage4.md
# pp_in_stage4

Four-port ingress staging block for the packet-processing pipeline, sitting directly upstream of the 4-input round-robin arbiter. It buffers descriptors from four producers in per-port FIFOs, drives the arbiter's request vector and advance enable, consumes the arbiter's registered port select, and forwards the selected descriptor through a registered output stage with a valid/ready handshake.

## Interface
- DW, 64: descriptor width in bits.
- DEPTH, 4: per-port FIFO depth. Power of two, at least 2.
- clk  in  1  the single clock.
- `RESET_SIG`  in  1  reset port, named as the codebase names it. Synchronous, active-high.
- in_vld  in  4  per-port descriptor valid.
- in_data  in  4*DW  per-port descriptor. Port p uses bits [p*DW +: DW].
- in_rdy  out  4  per-port FIFO not full.
- arb_req  out  4  to the arbiter. Bit p = FIFO p not empty.
- arb_en  out  1  to the arbiter. Advances its pointer this cycle.
- arb_sel  in  2  from the arbiter. Currently selected port; registered on the arbiter side.
- out_vld  out  1  output descriptor valid.
- out_data  out  DW  output descriptor.
- out_port  out  2  source port of out_data.
- out_rdy  in  1  downstream accepts.
- cnt_out  out  64  four 16-bit per-port pop counters, port p at [p*16 +: 16]. Present only with the configuration macro.

## Operation
- Push on port p: in_vld[p] & in_rdy[p]. in_rdy[p] = ~full[p] and depends only on the FIFO count, not on same-cycle pops.
- Occupancy per port is a counter of width clog2(DEPTH)+1. Read and write pointers are clog2(DEPTH) bits and wrap naturally.
- Output stage space: space = ~out_vld | out_rdy.
- Pop: pop = arb_req[arb_sel] & space.
  - On a pop, FIFO[arb_sel] head loads into out_data, out_port <= arb_sel, out_vld <= 1.
  - If out_vld & out_rdy & ~pop, then out_vld <= 0.
- arb_en = pop | ~arb_req[arb_sel]. The pointer moves after each service, or off an empty port. A stalled output with the selected port non-empty holds the pointer.
- Fairness comes entirely from the arbiter. This block never overrides arb_sel.
- Simultaneous push and pop on the same port in the same cycle: both take effect and the count is unchanged.
- A push into an empty FIFO becomes poppable the next cycle. There is no same-cycle bypass.
- Reset:
  - All FIFO counts and pointers go to 0.
  - out_vld = 0, out_data = 0, out_port = 0.
  - in_rdy = 4'hF from the first cycle after reset.
  - arb_req = 0, so arb_en = 1.
  - Counters are cleared.
  - Reset mid-operation discards all buffered and in-flight descriptors.

## Timing
- Minimum latency from input push to out_vld: 2 cycles (push cycle, then pop cycle, then registered output).
- Throughput is 1 descriptor/cycle when out_rdy is held high and any port is non-empty, provided the arbiter pointer lands on a requesting port. A one-cycle bubble occurs when arb_sel points to an empty port.
- out_data, out_port and out_vld are registered.
- in_rdy, arb_req and arb_en are combinational from registers and arb_sel. arb_en is also combinational from out_rdy.
- out_data and out_port must stay stable while out_vld & ~out_rdy.

## Configuration
- PP_IN_STAGE_CNT_EN defined:
  - Four 16-bit pop counters, one per port, increment on pop of that port.
  - Counters saturate at 16'hFFFF and are cleared by reset.
  - Counters are driven on cnt_out.
- PP_IN_STAGE_CNT_EN undefined:
  - No counter logic.
  - The cnt_out port is absent.

## Structure
- Shared package constants: PP_NPORT = 4, PP_PORT_W = 2, PP_CNT_W = 16.
- One sub-module, pp_desc_fifo:
  - Single-clock FIFO with DW and DEPTH parameters.
  - Ports push, pop, din, dout, full, empty.
  - Instantiated 4 times.

## Test plan
- Reset: after reset, in_rdy = 4'hF, out_vld = 0, arb_req = 0, arb_en = 1 (and cnt_out = 0 when the counters are compiled in).
- Single port: push 3 descriptors on port 2 (0xA, 0xB, 0xC) with arb_sel tied to 2 and out_rdy = 1 → out_vld from cycle 2, data 0xA, 0xB, 0xC on consecutive cycles, out_port = 2.
- Fill and full: 4 pushes to port 0 with out_rdy = 0 → in_rdy[0] = 0 after the 4th push. A 5th in_vld is not accepted.
- Output stall: out_rdy = 0 with out_vld = 1 and arb_sel on a non-empty port → out_data held, arb_en = 0, no pop. Raising out_rdy resumes with the next descriptor the following cycle.
- Round robin with a behavioural arbiter model: all 4 ports loaded with 2 descriptors each → out_port sequence 1, 2, 3, 0, 1, 2, 3, 0 from reset pointer 0. With the counters compiled in, each count ends at 2.
- Reset mid-stream: assert reset while 3 descriptors are buffered and out_vld = 1 → next cycle out_vld = 0, arb_req = 0. The stale data never reappears.
